// File: rtl/vga_sync_monitor.sv
// Sink-side VGA sync monitor: locks to incoming hs/vs frame structure,
// regenerates active-area coordinates and reports measured timing.
module vga_sync_monitor #(
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int MAX_COUNT   = 2047
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pix_ce_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic        locked_o,
    output logic        de_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic [10:0] line_len_o,
    output logic [10:0] frame_lines_o,
    output logic        err_o
);

    typedef enum logic [1:0] {UNLOCKED, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [10:0] MAXC = 11'(MAX_COUNT);
    localparam logic [10:0] H0   = 11'(H_START);
    localparam logic [10:0] H1   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V0   = 11'(V_START);
    localparam logic [10:0] V1   = 11'(V_START + V_ACTIVE);
    localparam logic [9:0]  HX   = 10'(H_START);
    localparam logic [9:0]  VY   = 10'(V_START);
    localparam logic [3:0]  LF   = 4'(LOCK_FRAMES);

    state_t      state, state_nx;
    logic        hs_q, vs_q, primed, vs_pend, vs_pend_nx;
    logic        len_cap, cap_nx;
    logic [3:0]  match_cnt, cnt_nx;
    logic [10:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
    logic [10:0] hlen, flines, len_nx, lines_nx;
    logic        hfall, vfall, line0, wd, len_bad, frm_bad, err_nx;
    logic        h_in, v_in, de_nx;
    logic [9:0]  x_nx, y_nx;

    // The first strobe after reset only primes the edge detectors.
    assign hfall  = pix_ce_i & primed & hs_q & ~hs_i;
    assign vfall  = pix_ce_i & primed & vs_q & ~vs_i;
    assign line0  = hfall & vs_pend;
    assign hlen   = hcnt + 11'd1;
    assign flines = vcnt + 11'd1;

    always_comb begin
        hcnt_nx = hcnt;
        vcnt_nx = vcnt;
        if (hfall)
            hcnt_nx = '0;
        else if (pix_ce_i && hcnt != MAXC)
            hcnt_nx = hcnt + 11'd1;
        if (line0)
            vcnt_nx = '0;
        else if (hfall && vcnt != MAXC)
            vcnt_nx = vcnt + 11'd1;
    end

    assign vs_pend_nx = vfall | (vs_pend & ~hfall);
    assign wd = pix_ce_i &
                ((hcnt_nx == MAXC && hcnt != MAXC) |
                 (vcnt_nx == MAXC && vcnt != MAXC));
    assign len_bad = hfall & len_cap & (hlen != line_len_o);
    assign frm_bad = line0 & (flines != frame_lines_o);

    always_comb begin
        state_nx = state;
        cnt_nx   = match_cnt;
        cap_nx   = len_cap;
        len_nx   = line_len_o;
        lines_nx = frame_lines_o;
        err_nx   = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (line0) begin
                    state_nx = MEASURE;
                    cap_nx   = 1'b0;
                end
            end
            MEASURE: begin
                if (hfall && !len_cap) begin
                    len_nx = hlen;
                    cap_nx = 1'b1;
                end else if (len_bad) begin
                    state_nx = UNLOCKED;
                end else if (line0) begin
                    lines_nx = flines;
                    cnt_nx   = '0;
                    state_nx = VERIFY;
                end
            end
            VERIFY: begin
                if (len_bad || frm_bad)
                    state_nx = UNLOCKED;
                else if (line0) begin
                    if (match_cnt + 4'd1 >= LF)
                        state_nx = LOCKED;
                    else
                        cnt_nx = match_cnt + 4'd1;
                end
            end
            LOCKED: begin
                if (len_bad || frm_bad) begin
                    state_nx = UNLOCKED;
                    err_nx   = 1'b1;
                end
            end
        endcase
        if (wd) begin
            state_nx = UNLOCKED;
            err_nx   = (state == LOCKED);
        end
    end

    assign h_in  = (hcnt_nx >= H0) && (hcnt_nx < H1);
    assign v_in  = (vcnt_nx >= V0) && (vcnt_nx < V1);
    assign de_nx = (state_nx == LOCKED) && h_in && v_in;
    assign x_nx  = de_nx ? hcnt_nx[9:0] - HX : '0;
    assign y_nx  = de_nx ? vcnt_nx[9:0] - VY : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= UNLOCKED;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            primed        <= 1'b0;
            vs_pend       <= 1'b0;
            len_cap       <= 1'b0;
            match_cnt     <= '0;
            hcnt          <= '0;
            vcnt          <= '0;
            locked_o      <= 1'b0;
            de_o          <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            line_len_o    <= '0;
            frame_lines_o <= '0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_nx;
            len_cap       <= cap_nx;
            match_cnt     <= cnt_nx;
            line_len_o    <= len_nx;
            frame_lines_o <= lines_nx;
            err_o         <= err_nx;
            locked_o      <= (state_nx == LOCKED);
            if (pix_ce_i) begin
                hs_q    <= hs_i;
                vs_q    <= vs_i;
                primed  <= 1'b1;
                vs_pend <= vs_pend_nx;
                hcnt    <= hcnt_nx;
                vcnt    <= vcnt_nx;
                de_o    <= de_nx;
                x_o     <= x_nx;
                y_o     <= y_nx;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled 32x16 frame
// so that several lock/relock cycles fit in a short run.
module tb_vga_sync_monitor;

    localparam int HT   = 32;
    localparam int HS_W = 4;
    localparam int VT   = 16;
    localparam int HST  = 6;
    localparam int HACT = 20;
    localparam int VST  = 2;
    localparam int VACT = 10;
    localparam int MAXC = 63;

    logic        clk = 1'b0;
    logic        reset_i, pix_ce_i, hs_i, vs_i;
    logic        locked_o, de_o, err_o;
    logic [9:0]  x_o, y_o;
    logic [10:0] line_len_o, frame_lines_o;

    vga_sync_monitor #(
        .H_START(HST), .V_START(VST), .H_ACTIVE(HACT),
        .V_ACTIVE(VACT), .LOCK_FRAMES(2), .MAX_COUNT(MAXC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .pix_ce_i(pix_ce_i),
        .hs_i(hs_i), .vs_i(vs_i), .locked_o(locked_o), .de_o(de_o),
        .x_o(x_o), .y_o(y_o), .line_len_o(line_len_o),
        .frame_lines_o(frame_lines_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f; int l; int p;
        int lk; int de; int x; int y; int len; int lines;
    } vec_t;

    vec_t tbl[14];
    int   errors = 0;
    int   checks = 0;
    int   gl, gp, frames, glitch_line;
    int   sf, sl, sp;
    bit   hs_hold, irr, lock_seen;
    int   lock_f, lock_l, lock_p;
    int   err_pulses, err_gap, de_cnt;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int gapv();
        return irr ? int'($urandom_range(0, 5)) : 1;
    endfunction

    task automatic pix(input int gap);
        hs_i = hs_hold ? 1'b1 : (gp >= HS_W);
        vs_i = !(gl == VT - 1 || gl == 0);
        pix_ce_i = 1'b1;
        @(posedge clk);
        #1;
        pix_ce_i = 1'b0;
        sf = frames; sl = gl; sp = gp;
        if (err_o) err_pulses++;
        if (de_o) de_cnt++;
        if (locked_o && !lock_seen) begin
            lock_seen = 1'b1;
            lock_f = sf; lock_l = sl; lock_p = sp;
        end
        gp++;
        if (gp == ((gl == glitch_line) ? HT + 1 : HT)) begin
            gp = 0;
            gl++;
            if (gl == VT) begin
                gl = 0;
                frames++;
            end
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            if (err_o) err_gap++;
        end
    endtask

    task automatic run_to(input int f, input int l, input int p);
        int n;
        n = 0;
        while (!(sf == f && sl == l && sp == p)) begin
            if (n == 6000) begin
                chk($sformatf("run_to %0d.%0d.%0d timeout", f, l, p), 0, 1);
                break;
            end
            pix(gapv());
            n++;
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, " locked"}, locked_o, 0);
        chk({t, " de"}, de_o, 0);
        chk({t, " x"}, x_o, 0);
        chk({t, " y"}, y_o, 0);
        chk({t, " len"}, line_len_o, 0);
        chk({t, " lines"}, frame_lines_o, 0);
        chk({t, " err"}, err_o, 0);
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic run_table(input string t);
        for (int i = 0; i < 14; i++) begin
            run_to(tbl[i].f, tbl[i].l, tbl[i].p);
            chk($sformatf("%s v%0d locked", t, i), locked_o, tbl[i].lk);
            chk($sformatf("%s v%0d de", t, i), de_o, tbl[i].de);
            chk($sformatf("%s v%0d x", t, i), x_o, tbl[i].x);
            chk($sformatf("%s v%0d y", t, i), y_o, tbl[i].y);
            chk($sformatf("%s v%0d len", t, i), line_len_o, tbl[i].len);
            chk($sformatf("%s v%0d lines", t, i), frame_lines_o, tbl[i].lines);
        end
    endtask

    task automatic check_frame(input string t, input int f);
        logic [20:0] e;
        bit act;
        run_to(f, 0, 0);
        de_cnt = 0;
        for (int i = 1; i < HT * VT; i++) begin
            pix(gapv());
            act = sp >= HST && sp < HST + HACT && sl >= VST && sl < VST + VACT;
            e = act ? {1'b1, 10'(sp - HST), 10'(sl - VST)} : 21'd0;
            chk($sformatf("%s px %0d.%0d", t, sl, sp), {de_o, x_o, y_o}, e);
        end
        chk({t, " de count"}, de_cnt, HACT * VACT);
    endtask

    task automatic gen_start();
        gl = VT - 4; gp = 0; frames = 0; sf = -1; sl = -1; sp = -1;
        glitch_line = -1; hs_hold = 1'b0; lock_seen = 1'b0;
        err_pulses = 0;
    endtask

    initial begin
        tbl[0]  = '{0, 12, 0,  0, 0, 0,  0, 0,  0};
        tbl[1]  = '{1, 0,  0,  0, 0, 0,  0, 0,  0};
        tbl[2]  = '{1, 1,  0,  0, 0, 0,  0, 32, 0};
        tbl[3]  = '{2, 0,  0,  0, 0, 0,  0, 32, 16};
        tbl[4]  = '{3, 15, 31, 0, 0, 0,  0, 32, 16};
        tbl[5]  = '{4, 0,  0,  1, 0, 0,  0, 32, 16};
        tbl[6]  = '{4, 2,  5,  1, 0, 0,  0, 32, 16};
        tbl[7]  = '{4, 2,  6,  1, 1, 0,  0, 32, 16};
        tbl[8]  = '{4, 2,  25, 1, 1, 19, 0, 32, 16};
        tbl[9]  = '{4, 2,  26, 1, 0, 0,  0, 32, 16};
        tbl[10] = '{4, 5,  10, 1, 1, 4,  3, 32, 16};
        tbl[11] = '{4, 11, 25, 1, 1, 19, 9, 32, 16};
        tbl[12] = '{4, 12, 6,  1, 0, 0,  0, 32, 16};
        tbl[13] = '{5, 0,  0,  1, 0, 0,  0, 32, 16};

        reset_i = 1'b1; pix_ce_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1;
        err_gap = 0; de_cnt = 0; irr = 1'b0;
        gen_start();
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk_zero("reset");

        // nominal lock and active area
        run_table("nom");
        chk("nom lock frame", lock_f, 4);
        chk("nom lock line", lock_l, 0);
        chk("nom lock pix", lock_p, 0);
        check_frame("nom", 5);
        chk("nom err pulses", err_pulses, 0);

        // one line of 33 pixels while locked
        run_to(6, 3, 30);
        glitch_line = 3;
        pix(1);
        pix(1);
        chk("glitch pre locked", locked_o, 1);
        chk("glitch pre err", err_pulses, 0);
        pix(1);
        chk("glitch err pulse", err_pulses, 1);
        chk("glitch err drop", err_o, 0);
        chk("glitch locked", locked_o, 0);
        chk("glitch de", de_o, 0);
        chk("glitch len held", line_len_o, 32);
        glitch_line = -1;
        run_to(9, 15, 31);
        chk("glitch relock early", locked_o, 0);
        run_to(10, 0, 0);
        chk("glitch relock", locked_o, 1);
        chk("glitch relock len", line_len_o, 32);
        chk("glitch relock err", err_pulses, 1);

        // hsync held high until hcnt saturates
        run_to(10, 5, 31);
        hs_hold = 1'b1;
        run_to(10, 6, 30);
        chk("nohs pre locked", locked_o, 1);
        chk("nohs pre err", err_pulses, 1);
        pix(1);
        chk("nohs err pulse", err_pulses, 2);
        chk("nohs locked", locked_o, 0);
        run_to(10, 11, 31);
        chk("nohs single err", err_pulses, 2);
        hs_hold = 1'b0;
        run_to(13, 15, 31);
        chk("nohs relock early", locked_o, 0);
        run_to(14, 0, 0);
        chk("nohs relock", locked_o, 1);

        // reset mid-frame; first post-reset sample carries hs+vs falls
        run_to(14, 14, 31);
        chk("rst pre locked", locked_o, 1);
        pulse_reset();
        chk_zero("midrst");
        run_to(15, 5, 0);
        chk("midrst no measure", line_len_o, 0);
        chk("midrst unlocked", locked_o, 0);
        run_to(16, 1, 0);
        chk("midrst measure len", line_len_o, 32);
        run_to(18, 15, 31);
        chk("midrst relock early", locked_o, 0);
        run_to(19, 0, 0);
        chk("midrst relock", locked_o, 1);

        // irregular strobe gaps must reproduce the nominal results
        gen_start();
        pulse_reset();
        irr = 1'b1;
        run_table("irr");
        chk("irr lock frame", lock_f, 4);
        chk("irr lock line", lock_l, 0);
        chk("irr lock pix", lock_p, 0);
        check_frame("irr", 5);
        chk("irr err pulses", err_pulses, 0);
        chk("err one clock", err_gap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
